// File: rtl/fifo_serializer.sv
// fifo_serializer -- pops IN_WIDTH words from an upstream show-ahead FIFO and
// emits them as RATIO beats of OUT_WIDTH bits over a valid/ready interface.
//
// Build option: define FIFO_SERIALIZER_MSB_FIRST_EN to emit the most
// significant slice of each word first; the default build emits LSB first.
//
// Ports
//   clk_i         clock, all state on rising edge
//   rst_ni        synchronous active-low reset
//   flush_i       synchronous flush, drops any held word
//   fifo_empty_i  upstream FIFO empty flag
//   fifo_data_i   upstream FIFO head word (valid while fifo_empty_i=0)
//   fifo_pop_o    pop strobe, one word consumed per cycle high
//   valid_o       output beat valid
//   ready_i       downstream accepts beat
//   data_o        current beat (0 when idle)
//   last_o        current beat is the final beat of its word
//   busy_o        a word is held
module fifo_serializer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = IN_WIDTH / OUT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 fifo_empty_i,
    input  logic [IN_WIDTH-1:0]  fifo_data_i,
    output logic                 fifo_pop_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 last_o,
    output logic                 busy_o
);

    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

    // RATIO is derived; reject overrides and widths that do not split evenly.
    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2 || RATIO != IN_WIDTH / OUT_WIDTH) begin : g_bad_cfg
        $error("fifo_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with RATIO >= 2");
    end

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]   held_q, held_d;

    logic [RATIO-1:0][OUT_WIDTH-1:0] beats;
    logic [CW-1:0]                   sel;
    logic                            shifting;
    logic                            at_last;

    assign beats    = held_q;
    assign shifting = (state_q == S_SHIFT);
    assign at_last  = (cnt_q == CNT_LAST);

`ifdef FIFO_SERIALIZER_MSB_FIRST_EN
    assign sel = CNT_LAST - cnt_q;
`else
    assign sel = cnt_q;
`endif

    assign valid_o = shifting;
    assign busy_o  = shifting;
    assign last_o  = shifting && at_last;
    assign data_o  = shifting ? beats[sel] : '0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        held_d     = held_q;
        fifo_pop_o = 1'b0;

        // Reset and flush both suppress the pop combinationally; reset also
        // clears the register state in the flop block below.
        if (!rst_ni || flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            held_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!fifo_empty_i) begin
                        fifo_pop_o = 1'b1;
                        held_d     = fifo_data_i;
                        cnt_d      = '0;
                        state_d    = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (ready_i) begin
                        if (!at_last) begin
                            cnt_d = cnt_q + CW'(1);
                        end else if (!fifo_empty_i) begin
                            // Reload on the final handshake so back-to-back
                            // words stream without a bubble.
                            fifo_pop_o = 1'b1;
                            held_d     = fifo_data_i;
                            cnt_d      = '0;
                        end else begin
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
        end
    end

endmodule

// File: tb/tb_fifo_serializer.sv
module tb_fifo_serializer;

    localparam int IW = 32;
    localparam int OW = 8;
    localparam int R  = IW / OW;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          fifo_empty_i;
    logic [IW-1:0] fifo_data_i;
    logic          fifo_pop_o;
    logic          valid_o;
    logic          ready_i;
    logic [OW-1:0] data_o;
    logic          last_o;
    logic          busy_o;

    always #5 clk_i = ~clk_i;

    fifo_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_pop_o   (fifo_pop_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .last_o       (last_o),
        .busy_o       (busy_o)
    );

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] fq[$];   // upstream FIFO contents
    logic [OW:0]   hb[$];   // reference: beats still owed for the held word, {last,data}
    logic [OW:0]   acc[$];  // beats accepted downstream, {last,data}

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // A word becomes R beats in transmit order.
    function automatic void push_word(input logic [IW-1:0] w);
        for (int i = 0; i < R; i++) begin
`ifdef FIFO_SERIALIZER_MSB_FIRST_EN
            hb.push_back({i == R - 1, w[(R-1-i)*OW +: OW]});
`else
            hb.push_back({i == R - 1, w[i*OW +: OW]});
`endif
        end
    endfunction

    // Word as seen on the wire, packed with the first beat in the low byte.
    function automatic logic [31:0] wire_order(input logic [31:0] w);
`ifdef FIFO_SERIALIZER_MSB_FIRST_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // One cycle: drive, settle, compare against the reference, advance it.
    task automatic step(input logic rst, input logic fl, input logic rdy);
        logic exp_pop, exp_v;
        rst_ni       = rst;
        flush_i      = fl;
        ready_i      = rdy;
        fifo_empty_i = (fq.size() == 0);
        fifo_data_i  = (fq.size() != 0) ? fq[0] : $urandom;
        #1;
        exp_v   = (hb.size() != 0);
        exp_pop = rst && !fl && (fq.size() != 0) &&
                  (hb.size() == 0 || (hb.size() == 1 && rdy));
        chk("pop",   {31'b0, fifo_pop_o}, {31'b0, exp_pop});
        chk("valid", {31'b0, valid_o},    {31'b0, exp_v});
        chk("busy",  {31'b0, busy_o},     {31'b0, exp_v});
        chk("data",  {24'b0, data_o},     exp_v ? {24'b0, hb[0][OW-1:0]} : 32'h0);
        chk("last",  {31'b0, last_o},     exp_v ? {31'b0, hb[0][OW]} : 32'h0);
        if (valid_o && ready_i && rst) acc.push_back({last_o, data_o});
        if (!rst || fl) begin
            hb.delete();
        end else begin
            if (exp_v && rdy) void'(hb.pop_front());
            if (exp_pop) begin
                push_word(fq[0]);
                void'(fq.pop_front());
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_word(input string tag, input int base, input logic [31:0] word);
        logic [31:0] got;
        logic [3:0]  lasts;
        if (acc.size() < base + R) begin
            checks++;
            errors++;
            $error("FAIL %s got=%0d beats exp=%0d", tag, acc.size(), base + R);
        end else begin
            got   = '0;
            lasts = '0;
            for (int i = 0; i < R; i++) begin
                got      = got | (32'(acc[base+i][OW-1:0]) << (8 * i));
                lasts[i] = acc[base+i][OW];
            end
            chk(tag, got, wire_order(word));
            chk({tag, "_last"}, {28'b0, lasts}, 32'h8);
        end
    endtask

    initial begin
        logic r, f, rd;

        // Reset with a word already waiting: no pop while reset is held.
        fq.push_back(32'hA1B2C3D4);
        rst_ni = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        fifo_empty_i = 1'b0; fifo_data_i = fq[0];
        #1;
        chk("pop_in_reset", {31'b0, fifo_pop_o}, 32'h0);
        @(posedge clk_i);
        #1;
        repeat (2) step(1'b0, 1'b0, 1'b0);

        // Single word, ready high throughout.
        acc.delete();
        repeat (6) step(1'b1, 1'b0, 1'b1);
        check_word("single", 0, 32'hA1B2C3D4);
        chk("single_cnt", acc.size(), 4);

        // Two words back to back stream without a bubble.
        fq.push_back(32'h11223344);
        fq.push_back(32'h55667788);
        acc.delete();
        repeat (10) step(1'b1, 1'b0, 1'b1);
        check_word("pair0", 0, 32'h11223344);
        check_word("pair1", 4, 32'h55667788);
        chk("pair_cnt", acc.size(), 8);

        // Downstream stall for two cycles.
        fq.push_back(32'hA1B2C3D4);
        acc.delete();
        repeat (2) step(1'b1, 1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b1);
        check_word("stall", 0, 32'hA1B2C3D4);
        chk("stall_cnt", acc.size(), 4);

        // Flush mid-word; the handshake in the flush cycle still counts.
        fq.push_back(32'hA1B2C3D4);
        acc.delete();
        repeat (3) step(1'b1, 1'b0, 1'b1);
        fq.push_back(32'hCAFEF00D);
        step(1'b1, 1'b1, 1'b1);
        repeat (7) step(1'b1, 1'b0, 1'b1);
        check_word("flush_next", 3, 32'hCAFEF00D);
        chk("flush_cnt", acc.size(), 7);

        // Reset mid-word discards the rest; the next word starts at beat 0.
        fq.push_back(32'hA1B2C3D4);
        acc.delete();
        repeat (2) step(1'b1, 1'b0, 1'b1);
        fq.push_back(32'h01234567);
        step(1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b1, 1'b0, 1'b1);
        check_word("rst_next", 1, 32'h01234567);
        chk("rst_cnt", acc.size(), 5);

        // Random traffic against the reference.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0 && fq.size() < 8) fq.push_back($urandom);
            r  = ($urandom_range(0, 80) != 0);
            f  = ($urandom_range(0, 50) == 0);
            rd = ($urandom_range(0, 3) != 0);
            step(r, f, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_serializer.md
FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32: width of word popped from upstream FIFO.
REQ-002 SHALL have parameter OUT_WIDTH, default 8: width of each output beat.
REQ-003 SHALL have parameter RATIO, default IN_WIDTH/OUT_WIDTH: beats per word; derived, not to be overridden.
REQ-004 SHALL have port clk_i  input  1  clock; single clock domain, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port flush_i  input  1  synchronous flush; drops held word.
REQ-007 SHALL have port fifo_empty_i  input  1  upstream FIFO empty flag.
REQ-008 SHALL have port fifo_data_i  input  IN_WIDTH  upstream FIFO head word, valid while fifo_empty_i=0.
REQ-009 SHALL have port fifo_pop_o  output  1  pop strobe to upstream FIFO; one word consumed per cycle high.
REQ-010 SHALL have port valid_o  output  1  output beat valid.
REQ-011 SHALL have port ready_i  input  1  downstream accepts beat.
REQ-012 SHALL have port data_o  output  OUT_WIDTH  current beat.
REQ-013 SHALL have port last_o  output  1  current beat is final beat of its word.
REQ-014 SHALL have port busy_o  output  1  a word is held (state SHIFT).

Function
REQ-015 SHALL implement two states: IDLE (no word held), SHIFT (word held, beat counter cnt of width max(1,$clog2(RATIO))).
REQ-016 In IDLE with fifo_empty_i=0 and flush_i=0, SHALL assert fifo_pop_o combinationally that cycle, capture fifo_data_i into a holding register, set cnt=0, enter SHIFT.
REQ-017 fifo_pop_o SHALL never assert while fifo_empty_i=1.
REQ-018 In SHIFT, valid_o SHALL be 1; data_o SHALL be held[cnt*OUT_WIDTH +: OUT_WIDTH] (LSB first by default); last_o SHALL be 1 iff cnt==RATIO-1.
REQ-019 Handshake occurs when valid_o&ready_i; once valid_o=1, valid_o, data_o and last_o SHALL remain stable until handshake or flush/reset.
REQ-020 Handshake with cnt<RATIO-1 SHALL increment cnt by 1.
REQ-021 Handshake with cnt==RATIO-1 and fifo_empty_i=0 SHALL pop and load next word same cycle, cnt wraps to 0, stay SHIFT (zero-bubble throughput).
REQ-022 Handshake with cnt==RATIO-1 and fifo_empty_i=1 SHALL return to IDLE.
REQ-023 fifo_pop_o SHALL be 0 in SHIFT except in the REQ-021 cycle.
REQ-024 Latency: first beat of a word SHALL appear on data_o the cycle after its pop.
REQ-025 Sustained throughput SHALL be one beat per cycle while ready_i=1 and FIFO non-empty.
REQ-026 valid_o=0, last_o=0, busy_o=0 in IDLE; data_o in IDLE SHALL be 0.
REQ-027 flush_i=1 SHALL force fifo_pop_o=0 that cycle and enter IDLE with cnt=0 next cycle; a handshake in the flush cycle is still counted downstream but no further beats of that word SHALL follow.
REQ-028 Elaboration SHALL fail if IN_WIDTH is not a multiple of OUT_WIDTH or RATIO<2.

Reset
REQ-029 While rst_ni=0 at a rising edge, state SHALL become IDLE, cnt=0, holding register=0.
REQ-030 While rst_ni=0, fifo_pop_o SHALL be 0; after the reset edge valid_o, last_o, busy_o, data_o SHALL be 0.
REQ-031 Reset SHALL take priority over flush_i and any handshake; reset mid-word discards remaining beats.

Configuration
REQ-032 Macro FIFO_SERIALIZER_MSB_FIRST_EN defined: beat cnt SHALL be held[(RATIO-1-cnt)*OUT_WIDTH +: OUT_WIDTH] (most significant slice first).
REQ-033 Macro undefined: LSB-first ordering per REQ-018; all other behaviour identical in both builds.

Verification (IN_WIDTH=32, OUT_WIDTH=8)
REQ-034 FIFO holds 0xA1B2C3D4, ready_i=1 -> pop at cycle 0; data_o D4,C3,B2,A1 cycles 1-4; last_o only with A1; IDLE cycle 5.
REQ-035 FIFO holds 0x11223344 then 0x55667788, ready_i=1 -> 8 contiguous beats 44,33,22,11,88,77,66,55; second pop coincides with beat 11 handshake.
REQ-036 0xA1B2C3D4, ready_i=0 during cycles 2-3 -> data_o=C3, valid_o=1 stable cycles 2-4; B2 at cycle 5; no extra pop.
REQ-037 flush_i=1 after beats D4,C3 accepted -> valid_o=0 next cycle; next word 0xCAFEF00D starts with 0D.
REQ-038 rst_ni=0 for one edge after beat D4 -> valid_o=0, busy_o=0, no pop during reset; next word starts at beat 0.
REQ-039 Build with FIFO_SERIALIZER_MSB_FIRST_EN, word 0xA1B2C3D4 -> beats A1,B2,C3,D4, last_o with D4.
